// File: rtl/riscv_lsu_ctrl.sv
// RV32I load/store sequencer: drives a req/gnt/rvalid data port, aligns stores, extends loads.
// Define LSU_TIMEOUT_EN to add a REQ+WAIT watchdog that ends the access with bus_err_o.
module riscv_lsu_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_zext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_vld_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              cmd_bad;
  logic [3:0]        cmd_be;
  logic [31:0]       cmd_wdata;
  logic [31:0]       ld_shift, ld_data;
  logic              timeout_hit;
  logic              timed_out;

  // Command decode from the live inputs, registered on acceptance in StIdle.
  always_comb begin
    cmd_bad   = 1'b0;
    cmd_be    = 4'b1111;
    cmd_wdata = wdata_i;
    unique case (mem_size_i)
      2'b00: begin
        cmd_be    = 4'b0001 << addr_i[1:0];
        cmd_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        cmd_bad   = addr_i[0];
        cmd_be    = 4'b0011 << addr_i[1:0];
        cmd_wdata = {2{wdata_i[15:0]}};
      end
      2'b10:   cmd_bad = |addr_i[1:0];
      default: cmd_bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   ld_data = zext_q ? {24'h0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = zext_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    zext_d  = zext_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_en_i) begin
          wr_d    = mem_wr_i;
          size_d  = mem_size_i;
          zext_d  = mem_zext_i;
          addr_d  = addr_i;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          err_d   = cmd_bad;
          state_d = cmd_bad ? StDone : StReq;
        end
      end
      StReq: begin
        if (dmem_gnt_i) state_d = wr_q ? StDone : StWait;
        else if (timeout_hit) state_d = StDone;
      end
      StWait: begin
        if (dmem_rvalid_i) begin
          rdata_d = ld_data;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      zext_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;

  assign timeout_hit = ((state_q == StReq && !dmem_gnt_i) || (state_q == StWait && !dmem_rvalid_i))
                       && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (state_q == StIdle && mem_en_i) begin
      cnt_d = '0;
      to_d  = 1'b0;
    end else if (state_q == StReq || state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout_hit) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timed_out = to_q;
  assign bus_err_o = (state_q == StDone) && to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timed_out          = 1'b0;
  assign bus_err_o          = 1'b0;
`endif

  // Stall is combinational in StIdle so the core freezes in the same cycle it issues.
  assign stall_o      = (state_q == StIdle && mem_en_i) || state_q == StReq || state_q == StWait;
  assign dmem_req_o   = (state_q == StReq);
  assign dmem_we_o    = wr_q;
  assign dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;
  assign rdata_vld_o  = (state_q == StDone) && !wr_q && !err_q && !timed_out;
  assign misalign_o   = (state_q == StDone) && err_q;

endmodule
